// File: rtl/vend_pkg.sv
// vend_pkg: shared state encoding, change denominations and coin legality check
package vend_pkg;

    typedef enum logic [1:0] {IDLE, VEND, CHANGE} state_t;

    localparam int DEN_10 = 10;
    localparam int DEN_5  = 5;
    localparam int DEN_1  = 1;

    function automatic logic is_legal_coin(input logic [31:0] c);
        return c == DEN_10 || c == DEN_5 || c == DEN_1;
    endfunction

endpackage

// File: rtl/vend_change_gen.sv
// vend_change_gen: greedy 10/5/1 change picker; zero credit yields no coin
module vend_change_gen
    import vend_pkg::*;
#(
    parameter int COIN_W   = 8,
    parameter int CREDIT_W = 10
) (
    input  logic [CREDIT_W-1:0] credit,
    output logic [COIN_W-1:0]   coin,
    output logic [CREDIT_W-1:0] next_credit
);

    always_comb begin
        coin = credit >= CREDIT_W'(DEN_10) ? COIN_W'(DEN_10) :
               credit >= CREDIT_W'(DEN_5)  ? COIN_W'(DEN_5)  :
               credit != '0                ? COIN_W'(DEN_1)  : '0;
        next_credit = credit - CREDIT_W'(coin);
    end

endmodule

// File: rtl/vend_ctrl_param.sv
// vend_ctrl_param: parametrised vending controller with credit, vend,
// coin rejection, cancel/refund and serialized greedy change output
module vend_ctrl_param
    import vend_pkg::*;
#(
    parameter int                    COIN_W     = 8,
    parameter int                    CREDIT_W   = 10,
    parameter int                    N_DRINK    = 4,
    parameter int                    SEL_W      = 2,
    parameter logic [N_DRINK*8-1:0]  PRICES     = {8'd25, 8'd20, 8'd15, 8'd10},
    parameter int                    MAX_CREDIT = 99
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [COIN_W-1:0]   coin,
    input  logic                coin_valid,
    input  logic [SEL_W-1:0]    drink_sel,
    input  logic                sel_valid,
    input  logic                cancel,
    output logic [CREDIT_W-1:0] credit,
    output logic [N_DRINK-1:0]  avail,
    output logic                drink_valid,
    output logic [SEL_W-1:0]    drink_id,
    output logic                change_valid,
    output logic [COIN_W-1:0]   change_coin,
    output logic                coin_reject,
    output logic                sel_err,
    output logic                busy
);

    localparam int SUM_W = CREDIT_W + COIN_W + 1;

    if (MAX_CREDIT >= 2 ** CREDIT_W) begin : g_bad_max_credit
        $error("MAX_CREDIT does not fit in CREDIT_W bits");
    end

    state_t               state, state_nxt;
    logic [CREDIT_W-1:0]  credit_nxt, price, chg_next;
    logic [COIN_W-1:0]    chg_coin;
    logic [SUM_W-1:0]     sum;
    logic [7:0]           price_tab [N_DRINK];
    logic                 idle, in_range, coin_ok, sel_ok, take_sel, take_coin;

    for (genvar i = 0; i < N_DRINK; i++) begin : g_price
        assign price_tab[i] = PRICES[i*8 +: 8];
    end

    vend_change_gen #(.COIN_W(COIN_W), .CREDIT_W(CREDIT_W)) u_change (
        .credit      (credit),
        .coin        (chg_coin),
        .next_credit (chg_next)
    );

    always_comb begin
        idle      = state == IDLE;
        sum       = SUM_W'(credit) + SUM_W'(coin);
        coin_ok   = is_legal_coin(32'(coin)) && sum <= SUM_W'(MAX_CREDIT);
        in_range  = 32'(drink_sel) < N_DRINK;
        price     = in_range ? CREDIT_W'(price_tab[drink_sel]) : '0;
        sel_ok    = in_range && credit >= price;
        // cancel beats selection, selection beats coin
        take_sel  = idle && !cancel && sel_valid && sel_ok;
        take_coin = idle && !cancel && !sel_valid && coin_valid && coin_ok;
        credit_nxt = take_sel          ? credit - price :
                     take_coin         ? CREDIT_W'(sum) :
                     state == CHANGE   ? chg_next       : credit;
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else        state <= state_nxt;

    always_comb
        state_nxt = idle            ? (cancel ? (credit != '0 ? CHANGE : IDLE) : take_sel ? VEND : IDLE) :
                    state == VEND   ? (credit != '0 ? CHANGE : IDLE) :
                                      (chg_next != '0 ? CHANGE : IDLE);

    always_comb begin
        busy         = !idle;
        drink_valid  = state == VEND;
        change_valid = state == CHANGE;
        change_coin  = change_valid ? chg_coin : '0;
        for (int i = 0; i < N_DRINK; i++)
            avail[i] = idle && credit >= CREDIT_W'(price_tab[i]);
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            credit      <= '0;
            drink_id    <= '0;
            coin_reject <= 1'b0;
            sel_err     <= 1'b0;
        end else begin
            credit      <= credit_nxt;
            drink_id    <= take_sel ? drink_sel : drink_id;
            coin_reject <= coin_valid && !take_coin;
            sel_err     <= sel_valid && !take_sel && !(idle && cancel);
        end

endmodule

// File: doc/vend_ctrl_param.md
# vend_ctrl_param

Parametrised vending-machine controller: accumulates credit from validated coin pulses and publishes a per-drink availability mask. It vends a selected drink when credit covers the price, then returns change one coin per cycle using greedy 10/5/1 denominations. It is the next-generation core of the vending design, generalising drink count, prices and credit width, and adding coin rejection, cancel/refund and serialized change output.

## Interface
- COIN_W, 8, coin value bus width
- CREDIT_W, 10, credit register width
- N_DRINK, 4, number of drinks
- SEL_W, 2, drink index width (2**SEL_W >= N_DRINK)
- PRICES, {8'd25,8'd20,8'd15,8'd10}, packed N_DRINK x 8-bit price table, index 0 in LSBs (0=tea, 1=coke, 2=coffee, 3=milk)
- MAX_CREDIT, 99, credit ceiling
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- coin  in  COIN_W  inserted coin value, sampled when coin_valid=1
- coin_valid  in  1  one-cycle coin strobe
- drink_sel  in  SEL_W  selected drink index, sampled when sel_valid=1
- sel_valid  in  1  one-cycle selection strobe
- cancel  in  1  one-cycle refund request
- credit  out  CREDIT_W  current credit
- avail  out  N_DRINK  bit i=1 when credit >= PRICES[i] and state is IDLE
- drink_valid  out  1  one-cycle vend pulse
- drink_id  out  SEL_W  vended index, valid with drink_valid
- change_valid  out  1  one change coin this cycle
- change_coin  out  COIN_W  denomination 10, 5 or 1, valid with change_valid
- coin_reject  out  1  one-cycle pulse: coin returned, credit unchanged
- sel_err  out  1  one-cycle pulse: selection refused
- busy  out  1  high in VEND and CHANGE

## Operation
- States: IDLE, VEND, CHANGE.
- IDLE input priority in one cycle: cancel > sel_valid > coin_valid. A strobe losing arbitration is dropped; a dropped coin pulses coin_reject.
- Coin is accepted when its value is 1, 5 or 10 and credit+coin <= MAX_CREDIT. Accepted: credit += coin. Otherwise: coin_reject.
- sel_valid with drink_sel < N_DRINK and credit >= price: credit -= price, drink_id latched, go to VEND. Otherwise: sel_err, credit unchanged, stay IDLE.
- cancel: credit > 0 -> CHANGE; credit == 0 -> no effect.
- VEND: drink_valid=1 for exactly one cycle. Next state is CHANGE if the remaining credit > 0, else IDLE.
- CHANGE: each cycle emit the largest denomination <= credit (10, then 5, then 1) and subtract it. Return to IDLE in the cycle credit reaches 0.
- In VEND/CHANGE: coin_valid -> coin_reject; sel_valid -> sel_err; cancel is ignored.
- Arithmetic is unsigned with CREDIT_W-bit credit. MAX_CREDIT < 2**CREDIT_W; elaboration fails otherwise.

## Timing
- Reset (async assert, sync deassert at clk): state IDLE; credit 0; all pulses 0; drink_id 0; change_coin 0; busy 0; avail = bits where PRICES[i]==0.
- coin_valid at edge t -> credit updated and visible after edge t (same-cycle registered). avail follows credit combinationally.
- coin_reject, sel_err and drink_valid are registered, asserted the cycle after the triggering edge.
- Vend latency: sel_valid at edge t -> drink_valid high in cycle t+1; first change coin in cycle t+2.
- Change for credit C takes floor(C/10) + floor((C%10)/5) + C%5 consecutive cycles, with no gaps.
- Reset mid-VEND/CHANGE: transaction abandoned, credit lost, outputs go to their reset values immediately.

## Structure
- Package vend_pkg: state enum (IDLE, VEND, CHANGE); denomination constants DEN_10=10, DEN_5=5, DEN_1=1; function is_legal_coin.
- Sub-module vend_change_gen: combinational greedy denomination picker (credit in -> change_coin, next credit out), instantiated once.

## Test plan
- Reset, then coins 10, 5, 1, 10 -> credit 10, 15, 16, 26; avail 0001, 0011, 0011, 1111.
- Credit 26, select 2 (coffee) -> drink_valid with drink_id=2 next cycle; change 5 then 1 over 2 cycles; credit 0; IDLE.
- Credit 16, select 3 (milk) -> sel_err; credit stays 16; no change output.
- Coin 7 -> coin_reject. Credit 95 plus coin 10 -> coin_reject, credit stays 95.
- Credit 28, cancel -> change 10, 10, 5, 1, 1, 1 over 6 cycles. A coin inserted during CHANGE -> coin_reject.
- Same cycle sel_valid(tea) + coin_valid(5) at credit 10 -> tea vended, coin_reject, credit 0. Reset asserted during CHANGE -> all outputs 0 at once.
